// File: rtl/imm_pkg.sv
// Shared types and helpers for the immediate-generation stage.
// Format select encoding and XLEN legality check.
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_S     = 3'd0,
    IMM_J     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_I     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_Z     = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_sel_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion for all base formats.
// Reserved select yields zero and flags illegal.
module imm_expand
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  imm_sel_e           imm_sel,
  output logic [XLEN-1:0]    imm,
  output logic               illegal
);

  logic [5:0] shamt;
  logic       unused_opc;

  // RV64 shifts use a 6-bit amount, RV32 only 5
  assign shamt = (XLEN == 64) ? instr[25:20]
                              : {1'b0, instr[24:20]};

  assign unused_opc = ^instr[6:0];

  // select and sign/zero-extend the immediate field
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (imm_sel == IMM_S):
        imm = XLEN'($signed({instr[31:25],
                             instr[11:7]}));
      (imm_sel == IMM_J):
        imm = XLEN'($signed({instr[31],
                             instr[19:12],
                             instr[20],
                             instr[30:21],
                             1'b0}));
      (imm_sel == IMM_B):
        imm = XLEN'($signed({instr[31],
                             instr[7],
                             instr[30:25],
                             instr[11:8],
                             1'b0}));
      (imm_sel == IMM_U):
        imm = XLEN'($signed({instr[31:12],
                             12'b0}));
      (imm_sel == IMM_I):
        imm = XLEN'($signed(instr[31:20]));
      (imm_sel == IMM_SHAMT):
        imm = XLEN'(shamt);
      (imm_sel == IMM_Z):
        imm = XLEN'(instr[19:15]);
      (imm_sel == IMM_RSVD):
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage with a 2-entry skid buffer.
// Main register drives outputs; skid absorbs one stalled beat.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         imm_sel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
    logic             vld;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t new_e;
  logic rdy_q;
  logic acc, drn;
  logic [XLEN-1:0] exp_imm;
  logic exp_ill;

  imm_expand #(.XLEN(XLEN)) u_exp (
    .instr   (instr),
    .imm_sel (imm_sel_e'(imm_sel)),
    .imm     (exp_imm),
    .illegal (exp_ill)
  );

  assign new_e = '{imm: exp_imm, tag: in_tag,
                   ill: exp_ill, vld: 1'b1};
  assign acc   = in_valid & rdy_q;
  assign drn   = main_q.vld & out_ready;

  // next-state: refill main from skid first to keep FIFO order
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.vld = 1'b0;
      skid_d.vld = 1'b0;
    end else if (!main_q.vld || drn) begin
      if (skid_q.vld) begin
        main_d     = skid_q;
        skid_d.vld = 1'b0;
        if (acc) skid_d = new_e;
      end else begin
        main_d.vld = 1'b0;
        if (acc) main_d = new_e;
      end
    end else if (acc) begin
      skid_d = new_e;
    end
  end

  // state registers; ready tracks whether skid will be free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= ~skid_d.vld;
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_q.vld;
  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances in lockstep.
// Directed plan steps followed by randomized traffic vs. a queue model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr, in_tag;
  logic [2:0]  imm_sel;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32, tag32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] got_tag[$];
  logic [31:0] got_imm[$];
  logic [63:0] got_imm64[$];
  logic        got_ill[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
  );

  function automatic longint sext(longint v, int bits);
    if (v >= (longint'(1) << (bits - 1)))
      return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] ref_imm(
    input logic [31:0] i, input logic [2:0] sel,
    input int xlen, output logic ill);
    longint u, v;
    u = longint'(i);
    v = 0;
    ill = 1'b0;
    case (sel)
      3'd0: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      3'd1: v = sext((((u >> 31) & 1) << 20)
                   | (((u >> 12) & 255) << 12)
                   | (((u >> 20) & 1) << 11)
                   | (((u >> 21) & 1023) << 1), 21);
      3'd2: v = sext((((u >> 31) & 1) << 12)
                   | (((u >> 7) & 1) << 11)
                   | (((u >> 25) & 63) << 5)
                   | (((u >> 8) & 15) << 1), 13);
      3'd3: v = sext(u & 64'hFFFF_F000, 32);
      3'd4: v = sext(u >> 20, 12);
      3'd5: v = (xlen == 64) ? ((u >> 20) & 63)
                             : ((u >> 20) & 31);
      3'd6: v = (u >> 15) & 31;
      default: begin v = 0; ill = 1'b1; end
    endcase
    return v;
  endfunction

  function automatic exp_t mk(logic [31:0] i,
                              logic [2:0] s,
                              logic [31:0] t);
    exp_t e;
    logic il;
    logic [63:0] w;
    e.i64 = ref_imm(i, s, 64, il);
    e.ill = il;
    w = ref_imm(i, s, 32, il);
    e.i32 = w[31:0];
    e.tag = t;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // check state against model, then apply this edge's transfers
  task automatic tick();
    logic acc, drn;
    #1;
    chk("out_valid32", v32, q.size() != 0);
    chk("out_valid64", v64, q.size() != 0);
    chk("in_ready32", rdy32, q.size() < 2);
    chk("in_ready64", rdy64, q.size() < 2);
    if (v32 && q.size() != 0) begin
      chk("imm32", imm32, q[0].i32);
      chk("imm64", imm64, q[0].i64);
      chk("tag32", tag32, q[0].tag);
      chk("tag64", tag64, q[0].tag);
      chk("ill32", ill32, q[0].ill);
      chk("ill64", ill64, q[0].ill);
    end
    acc = in_valid && rdy32;
    drn = v32 && out_ready;
    if (drn && q.size() != 0) begin
      got_tag.push_back(tag32);
      got_imm.push_back(imm32);
      got_imm64.push_back(imm64);
      got_ill.push_back(ill32);
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc) q.push_back(mk(instr, imm_sel, in_tag));
    @(negedge clk);
  endtask

  task automatic send(logic [2:0] s, logic [31:0] i,
                      logic [31:0] t);
    in_valid = 1'b1;
    imm_sel  = s;
    instr    = i;
    in_tag   = t;
    tick();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_got();
    got_tag.delete();
    got_imm.delete();
    got_imm64.delete();
    got_ill.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; instr = '0; imm_sel = '0; in_tag = '0;

    #12;
    chk("rst_valid", v32, 0);
    chk("rst_ready", rdy32, 1);
    chk("rst_imm32", imm32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_tag", tag32, 0);
    chk("rst_ill", ill32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back formats at full throughput
    clr_got();
    send(3'd2, 32'hFE000EE3, 32'd1);
    send(3'd1, 32'h001000EF, 32'd2);
    send(3'd0, 32'hFE20AC23, 32'd3);
    send(3'd4, 32'hFFF00093, 32'd4);
    idle(1);
    chk("t1_count", got_imm.size(), 4);
    if (got_imm.size() == 4) begin
      chk("t1_b", got_imm[0], 32'hFFFFFFFC);
      chk("t1_j", got_imm[1], 32'h00000800);
      chk("t1_s", got_imm[2], 32'hFFFFFFF8);
      chk("t1_i", got_imm[3], 32'hFFFFFFFF);
      for (int k = 0; k < 4; k++)
        chk("t1_tag", got_tag[k], k + 1);
    end
    idle(1);

    // 64-bit specific expansions
    clr_got();
    send(3'd3, 32'hABCDE2B7, 32'd5);
    send(3'd5, 32'h03F09093, 32'd6);
    send(3'd6, 32'h000F8073, 32'd7);
    idle(2);
    chk("t2_count", got_imm64.size(), 3);
    if (got_imm64.size() == 3) begin
      chk("t2_u64", got_imm64[0], 64'hFFFFFFFFABCDE000);
      chk("t2_u32", got_imm[0], 32'hABCDE000);
      chk("t2_sh64", got_imm64[1], 64'h3F);
      chk("t2_sh32", got_imm[1], 32'h1F);
      chk("t2_z64", got_imm64[2], 64'h1F);
    end

    // backpressure fills main and skid
    clr_got();
    out_ready = 1'b0;
    send(3'd4, 32'h00100093, 32'd10);
    send(3'd4, 32'h00200093, 32'd11);
    in_valid = 1'b1; in_tag = 32'd12;
    instr = 32'h00300093;
    #1;
    chk("t3_ready_low", rdy32, 0);
    chk("t3_main_tag", tag32, 10);
    tick();
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      done = rdy32;
      tick();
    end
    chk("t3_accepted", done, 1);
    idle(3);
    chk("t3_count", got_tag.size(), 3);
    if (got_tag.size() == 3) begin
      chk("t3_o0", got_tag[0], 10);
      chk("t3_o1", got_tag[1], 11);
      chk("t3_o2", got_tag[2], 12);
    end

    // reserved select then a legal one
    clr_got();
    send(3'd7, 32'hDEADBEEF, 32'd20);
    send(3'd4, 32'h00500093, 32'd21);
    idle(2);
    chk("t4_count", got_ill.size(), 2);
    if (got_ill.size() == 2) begin
      chk("t4_ill", got_ill[0], 1);
      chk("t4_imm0", got_imm[0], 0);
      chk("t4_ok", got_ill[1], 0);
      chk("t4_imm5", got_imm[1], 5);
    end

    // flush with both entries full and a new beat offered
    clr_got();
    out_ready = 1'b0;
    send(3'd4, 32'h00100093, 32'd30);
    send(3'd4, 32'h00100093, 32'd31);
    flush = 1'b1; in_valid = 1'b1; in_tag = 32'd99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_valid", v32, 0);
    chk("t5_ready", rdy32, 1);
    out_ready = 1'b1;
    idle(3);
    chk("t5_nothing", got_tag.size(), 0);

    // asynchronous reset between edges
    send(3'd4, 32'h00100093, 32'd40);
    send(3'd4, 32'h00200093, 32'd41);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", v32, 0);
    chk("t6_imm32", imm32, 0);
    chk("t6_imm64", imm64, 0);
    chk("t6_ready", rdy32, 1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clr_got();
    send(3'd4, 32'h00700093, 32'd50);
    in_valid = 1'b0;
    #1;
    chk("t6_lat_valid", v32, 1);
    chk("t6_lat_tag", tag32, 50);
    chk("t6_lat_imm", imm32, 7);
    idle(2);

    // randomized traffic with sporadic flushes
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      instr     = $urandom;
      imm_sel   = 3'($urandom_range(0, 7));
      in_tag    = $urandom;
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage between instruction decode and execute. Expands the immediate for every RV32/RV64 base format and passes a sideband tag (PC or ROB index) through with it. A valid/ready handshake with a 2-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush handles branch redirects.

Parameters:
XLEN, 32, output immediate width; only 32 or 64 are legal. Elaboration fails for any other value.
TAG_W, 32, width of the sideband tag carried alongside each immediate.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous kill of all buffered entries.
in_valid  input  1  upstream holds a valid instruction.
in_ready  output  1  stage can accept; registered.
instr  input  32  raw instruction word.
imm_sel  input  3  format select (see Behaviour).
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  out_imm, out_tag and out_illegal are valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  expanded immediate.
out_tag  output  TAG_W  tag matching out_imm.
out_illegal  output  1  imm_sel was reserved (111).

Behaviour:
- imm_sel encoding and expansion ("sx" = sign-extend from instr[31] to XLEN):
  - 000 S: sx {instr[31:25], instr[11:7]}.
  - 001 J: sx {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 010 B: sx {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: sx {instr[31:12], 12'b0}. Upper bits replicate instr[31] when XLEN=64.
  - 100 I: sx instr[31:20].
  - 101 SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 110 Z (CSR zimm): zero-extended instr[19:15].
  - 111 reserved: imm = 0 and illegal = 1.
- Expansion is combinational on the input side. Results are captured on accept, so latency is 1 cycle from accept to out_valid.
- Storage: a main register (drives the outputs) and a skid register. Each holds {imm, tag, illegal, valid}.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Main empty, or main draining: an accepted entry goes to main, unless skid is valid, in which case skid moves to main and the new entry goes to skid.
- Main full and not draining: an accepted entry goes to skid.
- in_ready is registered as ~skid_valid_next. At most one cycle of in_ready=1 can occur while main is stalled; the skid absorbs that beat.
- Throughput: 1 entry per cycle when out_ready is held high.
- Ordering is strictly FIFO. The skid always drains before any newer entry.
- Outputs are stable while out_valid=1 and out_ready=0.
- flush: next cycle both valid bits are 0 and in_ready=1. Flush beats any accept or drain in the same cycle, so an entry presented during flush is dropped.
- Reset (asynchronous assert, synchronous release): out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0, and both valid bits clear. Reset asserted mid-transfer discards all entries.
- Data registers are reset to 0 so out_imm is never X, even when out_valid=0.

Decomposition:
- Package imm_pkg holds:
  - the enum imm_sel_e {IMM_S, IMM_J, IMM_B, IMM_U, IMM_I, IMM_SHAMT, IMM_Z, IMM_RSVD}, 3 bits;
  - localparam INSTR_W=32;
  - a function, or the checked condition, for XLEN legality.
- Sub-module imm_expand is purely combinational: (instr, imm_sel) -> (imm[XLEN-1:0], illegal). imm_gen_stage instantiates it and owns the skid/handshake logic.

Test Plan:
1. XLEN=32, out_ready=1. Send B 0xFE000EE3, J 0x001000EF, S 0xFE20AC23, I 0xFFF00093 back-to-back, tags 1..4. Expect imm 0xFFFFFFFC, 0x00000800, 0xFFFFFFF8, 0xFFFFFFFF on 4 consecutive cycles, 1 cycle after each accept, tags in order.
2. XLEN=64. Send U 0xABCDE2B7 -> 0xFFFFFFFFABCDE000. SHAMT with 0x03F09093 -> 0x3F. Z with instr[19:15]=0x1F -> 0x1F.
3. Backpressure: out_ready=0 while streaming tags 10, 11, 12. Main holds 10, skid holds 11, in_ready drops the cycle after 11 is accepted, and 12 waits. Release out_ready: outputs are 10, 11, 12 in order with no loss or duplicate.
4. imm_sel=111 with any instr -> out_imm=0, out_illegal=1. The next I-type entry shows out_illegal=0.
5. Both registers full, then flush asserted together with in_valid=1. Next cycle out_valid=0 and in_ready=1. The flushed-cycle input never appears on the output.
6. Assert rst_n=0 asynchronously mid-stream, between clock edges. Outputs clear immediately (out_valid=0, out_imm=0). After release, the first accepted entry appears 1 cycle later.
